// File: rtl/usb_tx_bit_timer_if.sv
`default_nettype none
// ============================================================================
// usb_tx_bit_timer_if : handshake bundle between TX control FSM and bit timer
// Revision: 1.0
// ============================================================================
interface usb_tx_bit_timer_if #(
  parameter int BITS_PER_BYTE = 8,
  parameter int BYTE_CNT_W    = 7
);
  localparam int BIT_IDX_W = $clog2(BITS_PER_BYTE);

  logic                  transmitting;
  logic [BYTE_CNT_W-1:0] byte_count;
  logic                  transmit_empty;
  logic                  stuff_req;
  logic                  tx_shift;
  logic                  stuff_bit;
  logic                  byte_sent;
  logic                  data_sent;
  logic                  busy;
  logic [BIT_IDX_W-1:0]  bit_index;

  modport master (
    output transmitting, byte_count, transmit_empty, stuff_req,
    input  tx_shift, stuff_bit, byte_sent, data_sent, busy, bit_index
  );

  modport slave (
    input  transmitting, byte_count, transmit_empty, stuff_req,
    output tx_shift, stuff_bit, byte_sent, data_sent, busy, bit_index
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// usb_tx_bit_timer : USB TX bit-period timer (shift, stuff, byte/packet ends)
// Revision: 1.0
// ============================================================================
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int BITS_PER_BYTE = 8,
  parameter int BYTE_CNT_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  usb_tx_bit_timer_if.slave  bus
);
  localparam int c_clk_w = $clog2(CLKS_PER_BIT);
  localparam int c_bit_w = $clog2(BITS_PER_BYTE);
  localparam logic [c_clk_w-1:0]    c_clk_last = c_clk_w'(CLKS_PER_BIT - 1);
  localparam logic [c_clk_w-1:0]    c_clk_one  = c_clk_w'(1);
  localparam logic [c_bit_w-1:0]    c_bit_last = c_bit_w'(BITS_PER_BYTE - 1);
  localparam logic [c_bit_w-1:0]    c_bit_one  = c_bit_w'(1);
  localparam logic [BYTE_CNT_W-1:0] c_rem_one  = BYTE_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ZERO = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [c_clk_w-1:0]    clk_cnt_q, clk_cnt_d;
  logic [c_bit_w-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0] remaining_q, remaining_d;
  logic                  end_req_q, end_req_d;

  logic w_boundary;
  logic w_last_bit;
  logic w_tx_shift;
  logic w_stuff_bit;
  logic w_byte_sent;
  logic w_data_sent;

  assign w_boundary = (clk_cnt_q == c_clk_last);
  assign w_last_bit = (bit_cnt_q == c_bit_last);

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    remaining_d = remaining_q;
    end_req_d   = end_req_q;
    w_tx_shift  = 1'b0;
    w_stuff_bit = 1'b0;
    w_byte_sent = 1'b0;
    w_data_sent = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.transmitting) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          end_req_d = 1'b0;
          if (bus.byte_count != '0) begin
            state_d     = ST_RUN;
            remaining_d = bus.byte_count;
          end else begin
            state_d = ST_ZERO;
          end
        end
      end

      ST_ZERO: begin
        w_data_sent = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_RUN: begin
        // Loss of transmitting overrides anything the boundary would do.
        if (!bus.transmitting) begin
          state_d     = ST_IDLE;
          clk_cnt_d   = '0;
          bit_cnt_d   = '0;
          remaining_d = '0;
          end_req_d   = 1'b0;
        end else begin
          if (bus.transmit_empty) begin
            end_req_d = 1'b1;
          end
          if (w_boundary) begin
            clk_cnt_d = '0;
            if (bus.stuff_req) begin
              w_stuff_bit = 1'b1;
            end else begin
              w_tx_shift = 1'b1;
              if (w_last_bit) begin
                bit_cnt_d   = '0;
                w_byte_sent = 1'b1;
                if (remaining_q != '0) begin
                  remaining_d = remaining_q - c_rem_one;
                end
                // A transmit_empty arriving on this very boundary also ends here.
                if ((remaining_q == c_rem_one) || end_req_q || bus.transmit_empty) begin
                  w_data_sent = 1'b1;
                  state_d     = ST_IDLE;
                  end_req_d   = 1'b0;
                  remaining_d = '0;
                end
              end else begin
                bit_cnt_d = bit_cnt_q + c_bit_one;
              end
            end
          end else begin
            clk_cnt_d = clk_cnt_q + c_clk_one;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      remaining_q <= '0;
      end_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      remaining_q <= remaining_d;
      end_req_q   <= end_req_d;
    end
  end

  // Pulses are suppressed in a reset cycle so a mid-packet reset is silent.
  assign bus.tx_shift  = w_tx_shift  & ~rst;
  assign bus.stuff_bit = w_stuff_bit & ~rst;
  assign bus.byte_sent = w_byte_sent & ~rst;
  assign bus.data_sent = w_data_sent & ~rst;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.bit_index = bit_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_usb_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// tb_usb_tx_bit_timer : randomized self-checking bench against an event model
// Revision: 1.0
// ============================================================================
module tb_usb_tx_bit_timer;
  localparam int CPB  = 8;
  localparam int BPB  = 8;
  localparam int BCW  = 7;
  localparam int BITW = $clog2(BPB);
  localparam int VW   = BITW + 5;
  localparam int TX = VW - 1, ST = VW - 2, BY = VW - 3, DS = VW - 4, BZ = VW - 5;
  localparam int MAXL = 1024;

  logic clk;
  logic rst;

  usb_tx_bit_timer_if #(.BITS_PER_BYTE(BPB), .BYTE_CNT_W(BCW)) bus ();

  usb_tx_bit_timer #(
    .CLKS_PER_BIT (CPB),
    .BITS_PER_BYTE(BPB),
    .BYTE_CNT_W   (BCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [VW-1:0] exp_v [0:MAXL-1];
  logic [VW-1:0] act_v [0:MAXL-1];
  bit            stuff_at [0:MAXL-1];
  int            end_cyc;

  function automatic logic [VW-1:0] outs_now();
    return {bus.tx_shift, bus.stuff_bit, bus.byte_sent, bus.data_sent, bus.busy, bus.bit_index};
  endfunction

  // Boundary cycles get no stuffing; other cycles carry noise that must be ignored.
  task automatic clear_stuff();
    for (int c = 0; c < MAXL; c++)
      stuff_at[c] = (c % CPB == 0) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  // Expected outputs from packet-level rules: bit periods end every CPB cycles
  // after start, each non-stuffed one carries a bit, every BPB bits close a byte.
  task automatic build_model(input int n, input int te, input int ab, input int len);
    int  shifts = 0;
    int  bytes  = 0;
    bit  done   = 0;
    logic [BITW-1:0] idx;
    end_cyc = len;
    for (int c = 0; c < len; c++) exp_v[c] = '0;
    if (n == 0) begin
      exp_v[1][DS] = 1'b1;
      end_cyc = 1;
      return;
    end
    for (int c = 1; c < len && !done; c++) begin
      idx = BITW'(shifts % BPB);
      exp_v[c] = '0;
      exp_v[c][BZ] = 1'b1;
      exp_v[c][BITW-1:0] = idx;
      if (ab >= 0 && c >= ab) begin
        done = 1;
        end_cyc = c;
      end else if (c % CPB == 0) begin
        if (stuff_at[c]) begin
          exp_v[c][ST] = 1'b1;
        end else begin
          shifts++;
          exp_v[c][TX] = 1'b1;
          if (shifts % BPB == 0) begin
            bytes++;
            exp_v[c][BY] = 1'b1;
            if (bytes == n || (te >= 1 && te <= c)) begin
              exp_v[c][DS] = 1'b1;
              done = 1;
              end_cyc = c;
            end
          end
        end
      end
    end
  endtask

  // The bench plays the control FSM: drops transmitting right after the packet ends.
  task automatic drive(input int n, input int te, input int ab, input bit use_rst, input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      bus.transmitting   = (c <= end_cyc) && !(ab >= 0 && c >= ab);
      rst                = use_rst && (c == ab);
      bus.byte_count     = (c == 0) ? BCW'(n) : BCW'($urandom);
      bus.transmit_empty = (c == te);
      bus.stuff_req      = stuff_at[c];
      @(negedge clk);
      act_v[c] = outs_now();
    end
    rst = 1'b0;
    bus.transmitting = 1'b0;
    bus.transmit_empty = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.transmitting = 1'b1;
    bus.byte_count = BCW'(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs_now() !== '0) begin
        n_errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, outs_now(), {VW{1'b0}});
      end
    end
    @(posedge clk);
    #1;
    bus.transmitting = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs_now() !== '0) begin
      n_errors++;
      $display("FAIL reset_release: got %b expected %b", outs_now(), {VW{1'b0}});
    end
  endtask

  task automatic test_single_byte();
    int cnt = 0;
    int ds = -1;
    clear_stuff();
    build_model(1, -1, -1, 80);
    drive(1, -1, -1, 1'b0, 80);
    for (int c = 0; c < 80; c++) begin
      n_checks++;
      if (act_v[c] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL single_byte cycle %0d: got %b expected %b", c, act_v[c], exp_v[c]);
      end
      cnt += int'(act_v[c][TX]);
      if (act_v[c][DS] && ds < 0) ds = c;
    end
    n_checks++;
    if (cnt !== 8) begin n_errors++; $display("FAIL single_byte_shifts: got %0d expected 8", cnt); end
    n_checks++;
    if (ds !== 64) begin n_errors++; $display("FAIL single_byte_end: got %0d expected 64", ds); end
    n_checks++;
    if (act_v[65][BZ] !== 1'b0) begin n_errors++; $display("FAIL single_byte_busy65: got 1 expected 0"); end
  endtask

  task automatic test_two_bytes();
    int cnt = 0;
    clear_stuff();
    build_model(2, -1, -1, 140);
    drive(2, -1, -1, 1'b0, 140);
    for (int c = 0; c < 140; c++) begin
      n_checks++;
      if (act_v[c] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL two_bytes cycle %0d: got %b expected %b", c, act_v[c], exp_v[c]);
      end
      cnt += int'(act_v[c][TX]);
    end
    n_checks++;
    if (cnt !== 16) begin n_errors++; $display("FAIL two_bytes_shifts: got %0d expected 16", cnt); end
    n_checks++;
    if ({act_v[64][BY], act_v[64][DS], act_v[128][BY], act_v[128][DS]} !== 4'b1011) begin
      n_errors++;
      $display("FAIL two_bytes_marks: got %b expected 1011",
               {act_v[64][BY], act_v[64][DS], act_v[128][BY], act_v[128][DS]});
    end
  endtask

  task automatic test_stuff();
    int cnt = 0;
    clear_stuff();
    stuff_at[24] = 1'b1;
    build_model(1, -1, -1, 90);
    drive(1, -1, -1, 1'b0, 90);
    for (int c = 0; c < 90; c++) begin
      n_checks++;
      if (act_v[c] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL stuff cycle %0d: got %b expected %b", c, act_v[c], exp_v[c]);
      end
      cnt += int'(act_v[c][TX]);
    end
    n_checks++;
    if ({act_v[24][ST], act_v[24][TX], act_v[72][DS]} !== 3'b101) begin
      n_errors++;
      $display("FAIL stuff_marks: got %b expected 101", {act_v[24][ST], act_v[24][TX], act_v[72][DS]});
    end
    n_checks++;
    if (cnt !== 8) begin n_errors++; $display("FAIL stuff_shifts: got %0d expected 8", cnt); end
  endtask

  task automatic test_early_end();
    int ds = -1;
    clear_stuff();
    build_model(5, 70, -1, 200);
    drive(5, 70, -1, 1'b0, 200);
    for (int c = 0; c < 200; c++) begin
      n_checks++;
      if (act_v[c] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL early_end cycle %0d: got %b expected %b", c, act_v[c], exp_v[c]);
      end
      if (act_v[c][DS] && ds < 0) ds = c;
    end
    n_checks++;
    if (ds !== 128) begin n_errors++; $display("FAIL early_end_ds: got %0d expected 128", ds); end
  endtask

  task automatic test_abort(input bit use_rst);
    int cnt = 0;
    clear_stuff();
    build_model(3, -1, 30, 60);
    drive(3, -1, 30, use_rst, 60);
    for (int c = 0; c < 60; c++) begin
      n_checks++;
      if (act_v[c] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL abort(rst=%0d) cycle %0d: got %b expected %b", use_rst, c, act_v[c], exp_v[c]);
      end
      cnt += int'(act_v[c][TX]);
    end
    n_checks++;
    if (cnt !== 3 || act_v[31][BZ] !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_summary(rst=%0d): got shifts %0d busy31 %b expected 3 and 0", use_rst, cnt, act_v[31][BZ]);
    end
  endtask

  task automatic test_zero_length();
    clear_stuff();
    build_model(0, -1, -1, 6);
    drive(0, -1, -1, 1'b0, 6);
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (act_v[c] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL zero_length cycle %0d: got %b expected %b", c, act_v[c], exp_v[c]);
      end
    end
    n_checks++;
    if (act_v[1][DS] !== 1'b1) begin n_errors++; $display("FAIL zero_length_ds: got 0 expected 1"); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int n, te, ab, len, nst;
      bit ur;
      n   = $urandom_range(1, 3);
      len = (n * BPB + 8) * CPB + 16;
      clear_stuff();
      nst = 0;
      for (int c = CPB; c < len; c += CPB)
        if (nst < 6 && $urandom_range(0, 5) == 0) begin
          stuff_at[c] = 1'b1;
          nst++;
        end
      te = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * BPB * CPB) : -1;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(2, n * BPB * CPB) : -1;
      ur = 1'($urandom_range(0, 1));
      build_model(n, te, ab, len);
      drive(n, te, ab, ur, len);
      for (int c = 0; c < len; c++) begin
        n_checks++;
        if (act_v[c] !== exp_v[c]) begin
          n_errors++;
          $display("FAIL random it%0d (n=%0d te=%0d ab=%0d) cycle %0d: got %b expected %b",
                   it, n, te, ab, c, act_v[c], exp_v[c]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.transmitting   = 1'b0;
    bus.byte_count     = '0;
    bus.transmit_empty = 1'b0;
    bus.stuff_req      = 1'b0;
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_stuff();
    test_early_end();
    test_abort(1'b0);
    test_abort(1'b1);
    test_zero_length();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
